sie_owner_mux: RTL and testbench
================================

# sie_owner_mux

Parametrised SIE ownership multiplexer: the successor of the two-way host/slave SIE-port mux. It selects one of NUM_SRC controllers (host, slave, test/loopback engines) to drive the shared SIE port and speed-control lines. Ownership changes are sequenced: drain the current owner's transfer, hold a quiet guard interval, then commit. It sits in the usbClk domain between the controller front-ends and the SIE.

## Interface
Parameters:
- NUM_SRC, 2, number of source controllers (2..8)
- RESET_OWNER, 0, owner index after reset
- GUARD_CYCLES, 4, quiet cycles between owners (>=1)
- TIMEOUT_CYCLES, 1024, drain limit (only with SIE_OWNER_MUX_TIMEOUT_EN)
- SEL_W (localparam), max(1, clog2(NUM_SRC))

Ports:
- usbClk  in  1  sole clock
- rstN  in  1  asynchronous, active-low reset
- ownerSel  in  SEL_W  requested owner (level)
- sieBusy  in  1  SIE is mid-packet
- ctrlIn  in  8*NUM_SRC  per-source SIEPortCtrlIn, source i at [8i+7:8i]
- dataIn  in  8*NUM_SRC  per-source SIEPortDataIn
- wEnIn  in  NUM_SRC  per-source SIEPortWEn
- polarityIn / bitRateIn / noActToIn  in  NUM_SRC each  per-source fullSpeedPolarity, fullSpeedBitRate, noActivityTimeOutEnable
- ctrlToSIE, dataToSIE  out  8 each  muxed port
- wEnToSIE, polarityToSIE, bitRateToSIE, noActToToSIE  out  1 each
- activeOwner  out  SEL_W  committed owner
- switching  out  1  high in DRAIN/GUARD
- switchDone  out  1  one-cycle pulse on commit
- timeoutErr  out  1  one-cycle pulse on drain timeout

## Operation
- All outputs registered. Reset: every data/control output 0, activeOwner=RESET_OWNER, target=RESET_OWNER, state RUN, counters 0.
- States RUN, DRAIN, GUARD.
- RUN: outputs <= source[activeOwner]. If ownerSel != activeOwner and ownerSel < NUM_SRC: target <= ownerSel, go DRAIN. ownerSel >= NUM_SRC is ignored.
- DRAIN: still passes source[activeOwner] through. If ownerSel == activeOwner, cancel to RUN with no pulse. If ownerSel is another valid index, target <= ownerSel (retarget). When sieBusy==0 and wEnIn[activeOwner]==0, go GUARD with guard counter loaded to GUARD_CYCLES-1.
- GUARD: wEnToSIE=0, ctrlToSIE=0, dataToSIE=0. Polarity, bitRate and noActTo hold the old owner's last values. Requests are ignored. At counter 0: activeOwner <= target, switchDone=1, go RUN.
- Each out-of-range source index is ignored, never wrapped.

## Timing
- RUN pass-through latency: 1 cycle.
- Request detected in cycle n -> switching=1 from n+1.
- Drain condition true in cycle m -> GUARD from m+1 for exactly GUARD_CYCLES cycles -> switchDone and new activeOwner in the same cycle. The new owner's data appears on outputs 1 cycle later.
- Minimum switch, with an idle SIE, from request to new data on the port: GUARD_CYCLES+3 cycles.
- Reset asserted mid-switch: immediate return to reset values, with no switchDone.
- If sieBusy and wEn fall in the same cycle that ownerSel changes back, the cancel takes priority.

## Configuration
- SIE_OWNER_MUX_TIMEOUT_EN defined:
  - DRAIN counts cycles from 0.
  - At TIMEOUT_CYCLES-1 without the drain condition: timeoutErr pulses and the block goes to GUARD regardless of sieBusy.
  - The counter clears on entry to DRAIN.
- Undefined: DRAIN waits indefinitely, timeoutErr is tied 0, and no counter is synthesised.

## Structure
- Shared package sie_owner_mux_pkg holds:
  - state enum (RUN/DRAIN/GUARD)
  - sie_port_t struct (ctrl[8], data[8], wEn, polarity, bitRate, noActTo)
  - SIE_IDLE constant (all zero)
- One sub-module, sie_owner_mux_sel: purely combinational NUM_SRC-way selection of sie_port_t by index. It is instantiated once for the output path.

## Test plan
- Reset, NUM_SRC=3, RESET_OWNER=1: outputs 0 during reset. After release, source1 ctrl=8'hA5 appears on ctrlToSIE 1 cycle later. activeOwner=1.
- Idle switch 1->2, GUARD_CYCLES=4:
  - switching rises the cycle after the request.
  - wEnToSIE=0 for 4 cycles.
  - switchDone pulses once.
  - dataToSIE = source2's 8'h3C one cycle after the pulse.
- Busy drain: sieBusy=1 for 20 cycles after the request. Owner data passes unchanged through DRAIN. GUARD starts the cycle after sieBusy falls.
- Cancel and retarget:
  - Request 0->1 then back to 0 during DRAIN: RUN resumes, with no switchDone.
  - Request 0->1 then 2 during DRAIN: commit to 2.
- ownerSel=3 with NUM_SRC=3: no state change, switching stays 0.
- Macro defined, TIMEOUT_CYCLES=16, sieBusy stuck 1: timeoutErr pulses at drain cycle 16, then GUARD and commit. With the macro undefined: the block stays in DRAIN for over 1000 cycles.

Source files
------------

// File: rtl/sie_owner_mux_pkg.sv
// Shared types for the SIE ownership multiplexer: FSM states, the bundled
// SIE port (control, data, write enable and speed-control lines) and its idle value.
package sie_owner_mux_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      GUARD = 2'd2
   } state_t;

   typedef struct packed {
      logic [7:0] ctrl;
      logic [7:0] data;
      logic       wEn;
      logic       polarity;
      logic       bitRate;
      logic       noActTo;
   } sie_port_t;

   localparam sie_port_t SIE_IDLE = '{
      ctrl:     8'h00,
      data:     8'h00,
      wEn:      1'b0,
      polarity: 1'b0,
      bitRate:  1'b0,
      noActTo:  1'b0
   };

endpackage

// File: rtl/sie_owner_mux_sel.sv
// Combinational NUM_SRC-way selection of one SIE port bundle by index.
// An index with no matching source yields SIE_IDLE rather than wrapping.
module sie_owner_mux_sel
   import sie_owner_mux_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int SEL_W   = 1
)(
   input  sie_port_t [NUM_SRC-1:0] src,
   input  logic [SEL_W-1:0]        idx,
   output sie_port_t               sel
);

   // pick the source whose index matches
   always_comb begin
      sel = SIE_IDLE;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (idx == SEL_W'(i)) sel = src[i];
      end
   end

endmodule

// File: rtl/sie_owner_mux.sv
// SIE ownership multiplexer. Passes the committed owner's SIE port through
// with one register stage; an ownership change drains the current owner,
// holds a quiet guard interval, then commits the new owner.
//
// Optional feature: define SIE_OWNER_MUX_TIMEOUT_EN to bound the drain
// phase to TIMEOUT_CYCLES and flag timeoutErr when it expires.
//
//   state | meaning
//   RUN   | committed owner drives the SIE port
//   DRAIN | switch pending, waiting for the owner's transfer to finish
//   GUARD | port quiet (no write, zero ctrl/data) before commit
module sie_owner_mux
   import sie_owner_mux_pkg::*;
#(
   parameter int   NUM_SRC        = 2,
   parameter int   RESET_OWNER    = 0,
   parameter int   GUARD_CYCLES   = 4,
   parameter int   TIMEOUT_CYCLES = 1024,
   localparam int  SEL_W          = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
)(
   input  logic                   usbClk,
   input  logic                   rstN,
   input  logic [SEL_W-1:0]       ownerSel,
   input  logic                   sieBusy,
   input  logic [8*NUM_SRC-1:0]   ctrlIn,
   input  logic [8*NUM_SRC-1:0]   dataIn,
   input  logic [NUM_SRC-1:0]     wEnIn,
   input  logic [NUM_SRC-1:0]     polarityIn,
   input  logic [NUM_SRC-1:0]     bitRateIn,
   input  logic [NUM_SRC-1:0]     noActToIn,
   output logic [7:0]             ctrlToSIE,
   output logic [7:0]             dataToSIE,
   output logic                   wEnToSIE,
   output logic                   polarityToSIE,
   output logic                   bitRateToSIE,
   output logic                   noActToToSIE,
   output logic [SEL_W-1:0]       activeOwner,
   output logic                   switching,
   output logic                   switchDone,
   output logic                   timeoutErr
);

   localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

   sie_port_t [NUM_SRC-1:0] src;
   sie_port_t               owner_port;
   sie_port_t               port_q;
   state_t                  state;
   logic [SEL_W-1:0]        target;
   logic [GW-1:0]           guard_cnt;
   logic                    sel_valid;
   logic                    sel_other;
   logic                    drained;
   logic                    timeout_hit;

   // gather the flat per-source buses into port bundles
   always_comb begin
      src = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src[i].ctrl     = ctrlIn[8*i +: 8];
         src[i].data     = dataIn[8*i +: 8];
         src[i].wEn      = wEnIn[i];
         src[i].polarity = polarityIn[i];
         src[i].bitRate  = bitRateIn[i];
         src[i].noActTo  = noActToIn[i];
      end
   end

   sie_owner_mux_sel #(
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_sel (
      .src (src),
      .idx (activeOwner),
      .sel (owner_port)
   );

   // out-of-range requests are dropped, never wrapped onto a real source
   assign sel_valid = ({1'b0, ownerSel} < (SEL_W+1)'(NUM_SRC));
   assign sel_other = sel_valid && (ownerSel != activeOwner);
   assign drained   = !sieBusy && !owner_port.wEn;

`ifdef SIE_OWNER_MUX_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] drain_cnt;

   assign timeout_hit = (state == DRAIN) && (drain_cnt == TW'(TIMEOUT_CYCLES-1));

   // count cycles spent in DRAIN; zero whenever outside it so entry starts at 0
   always_ff @(posedge usbClk or negedge rstN) begin
      if (!rstN)                drain_cnt <= '0;
      else if (state != DRAIN)  drain_cnt <= '0;
      else if (!timeout_hit)    drain_cnt <= drain_cnt + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // ownership sequencer and registered SIE port
   always_ff @(posedge usbClk or negedge rstN) begin
      if (!rstN) begin
         state       <= RUN;
         activeOwner <= SEL_W'(RESET_OWNER);
         target      <= SEL_W'(RESET_OWNER);
         guard_cnt   <= '0;
         port_q      <= SIE_IDLE;
         switching   <= 1'b0;
         switchDone  <= 1'b0;
         timeoutErr  <= 1'b0;
      end else begin
         switchDone <= 1'b0;
         timeoutErr <= 1'b0;
         case (state)
            RUN: begin
               port_q <= owner_port;
               if (sel_other) begin
                  target    <= ownerSel;
                  state     <= DRAIN;
                  switching <= 1'b1;
               end
            end
            DRAIN: begin
               port_q <= owner_port;
               // returning to the current owner wins over a same-cycle drain
               if (ownerSel == activeOwner) begin
                  state     <= RUN;
                  switching <= 1'b0;
               end else begin
                  if (sel_valid) target <= ownerSel;
                  if (drained || timeout_hit) begin
                     state      <= GUARD;
                     guard_cnt  <= GW'(GUARD_CYCLES-1);
                     timeoutErr <= timeout_hit && !drained;
                  end
               end
            end
            GUARD: begin
               // speed-control lines keep the old owner's values through the gap
               port_q.ctrl <= '0;
               port_q.data <= '0;
               port_q.wEn  <= 1'b0;
               if (guard_cnt == '0) begin
                  activeOwner <= target;
                  switchDone  <= 1'b1;
                  state       <= RUN;
                  switching   <= 1'b0;
               end else begin
                  guard_cnt <= guard_cnt - 1'b1;
               end
            end
            default: begin
               state     <= RUN;
               switching <= 1'b0;
            end
         endcase
      end
   end

   assign ctrlToSIE     = port_q.ctrl;
   assign dataToSIE     = port_q.data;
   assign wEnToSIE      = port_q.wEn;
   assign polarityToSIE = port_q.polarity;
   assign bitRateToSIE  = port_q.bitRate;
   assign noActToToSIE  = port_q.noActTo;

endmodule

// File: tb/tb_sie_owner_mux.sv
// Bench for sie_owner_mux: NUM_SRC=3, RESET_OWNER=1, GUARD_CYCLES=4,
// TIMEOUT_CYCLES=16. Commits are checked by a scoreboard monitor; timing
// around each switch is checked against hand-derived cycle numbers.
// Source constants: src0 ctrl 11/data 22, src1 A5/5A, src2 C3/3C;
// polarity 3'b010, bitRate 3'b101, noActTo 3'b110.
module tb_sie_owner_mux;

   logic        usbClk = 1'b0;
   logic        rstN   = 1'b1;
   logic [1:0]  ownerSel;
   logic        sieBusy;
   logic [23:0] ctrlIn;
   logic [23:0] dataIn;
   logic [2:0]  wEnIn;
   logic [2:0]  polarityIn;
   logic [2:0]  bitRateIn;
   logic [2:0]  noActToIn;
   logic [7:0]  ctrlToSIE;
   logic [7:0]  dataToSIE;
   logic        wEnToSIE;
   logic        polarityToSIE;
   logic        bitRateToSIE;
   logic        noActToToSIE;
   logic [1:0]  activeOwner;
   logic        switching;
   logic        switchDone;
   logic        timeoutErr;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [1:0] owner;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   logic       pend      = 1'b0;
   logic [7:0] pend_data = 8'h00;

   sie_owner_mux #(
      .NUM_SRC        (3),
      .RESET_OWNER    (1),
      .GUARD_CYCLES   (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .usbClk        (usbClk),
      .rstN          (rstN),
      .ownerSel      (ownerSel),
      .sieBusy       (sieBusy),
      .ctrlIn        (ctrlIn),
      .dataIn        (dataIn),
      .wEnIn         (wEnIn),
      .polarityIn    (polarityIn),
      .bitRateIn     (bitRateIn),
      .noActToIn     (noActToIn),
      .ctrlToSIE     (ctrlToSIE),
      .dataToSIE     (dataToSIE),
      .wEnToSIE      (wEnToSIE),
      .polarityToSIE (polarityToSIE),
      .bitRateToSIE  (bitRateToSIE),
      .noActToToSIE  (noActToToSIE),
      .activeOwner   (activeOwner),
      .switching     (switching),
      .switchDone    (switchDone),
      .timeoutErr    (timeoutErr)
   );

   always #5 usbClk = ~usbClk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge usbClk);
   endtask

   task automatic push(input logic [1:0] owner, input logic [7:0] data);
      exp_t e;
      e.owner = owner;
      e.data  = data;
      sb.push_back(e);
   endtask

   // scoreboard monitor: every switchDone pops one expected commit,
   // and the new owner's data is checked on the following cycle
   always @(negedge usbClk) begin
      exp_t e;
      if (pend) begin
         chk("sb_new_owner_data", 32'(dataToSIE), 32'(pend_data));
         pend = 1'b0;
      end
      if (switchDone) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_unexpected_done: switchDone with nothing expected, activeOwner=%0d", activeOwner);
         end else begin
            e = sb.pop_front();
            chk("sb_commit_owner", 32'(activeOwner), 32'(e.owner));
            pend      = 1'b1;
            pend_data = e.data;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      ownerSel   = 2'd1;
      sieBusy    = 1'b0;
      ctrlIn     = {8'hC3, 8'hA5, 8'h11};
      dataIn     = {8'h3C, 8'h5A, 8'h22};
      wEnIn      = 3'b000;
      polarityIn = 3'b010;
      bitRateIn  = 3'b101;
      noActToIn  = 3'b110;

      // reset values
      #1 rstN = 1'b0;
      tick(); tick();
      chk("rst_ctrl",     32'(ctrlToSIE), 32'h00);
      chk("rst_data",     32'(dataToSIE), 32'h00);
      chk("rst_pol",      32'(polarityToSIE), 32'd0);
      chk("rst_noact",    32'(noActToToSIE), 32'd0);
      chk("rst_owner",    32'(activeOwner), 32'd1);
      chk("rst_switching",32'(switching), 32'd0);
      rstN = 1'b1;
      tick();
      chk("run_ctrl_src1",  32'(ctrlToSIE), 32'hA5);
      chk("run_data_src1",  32'(dataToSIE), 32'h5A);
      chk("run_pol_src1",   32'(polarityToSIE), 32'd1);
      chk("run_rate_src1",  32'(bitRateToSIE), 32'd0);
      chk("run_noact_src1", 32'(noActToToSIE), 32'd1);
      chk("run_owner",      32'(activeOwner), 32'd1);

      // idle switch 1 -> 2
      ownerSel = 2'd2;
      wEnIn    = 3'b100;
      push(2'd2, 8'h3C);
      tick();
      chk("idle_switching_rise", 32'(switching), 32'd1);
      chk("idle_drain_old_ctrl", 32'(ctrlToSIE), 32'hA5);
      tick();
      chk("idle_drain_reg_ctrl", 32'(ctrlToSIE), 32'hA5);
      for (int k = 3; k <= 6; k++) begin
         tick();
         chk("guard_wen",      32'(wEnToSIE), 32'd0);
         chk("guard_ctrl",     32'(ctrlToSIE), 32'h00);
         chk("guard_data",     32'(dataToSIE), 32'h00);
         chk("guard_pol_hold", 32'(polarityToSIE), 32'd1);
         chk("guard_done",     32'(switchDone), 32'(k == 6));
      end
      chk("idle_commit_owner", 32'(activeOwner), 32'd2);
      tick();
      chk("idle_new_wen",   32'(wEnToSIE), 32'd1);
      chk("idle_new_pol",   32'(polarityToSIE), 32'd0);
      chk("idle_new_rate",  32'(bitRateToSIE), 32'd1);
      chk("idle_switch_end",32'(switching), 32'd0);
      chk("idle_done_once", 32'(switchDone), 32'd0);
      wEnIn = 3'b000;

      // busy drain 2 -> 0, sieBusy held 20 cycles
      ownerSel = 2'd0;
      sieBusy  = 1'b1;
      push(2'd0, 8'h22);
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk("busy_passthru_ctrl", 32'(ctrlToSIE), 32'hC3);
         chk("busy_switching",     32'(switching), 32'd1);
      end
      sieBusy = 1'b0;
      tick();
      chk("busy_last_drain_ctrl", 32'(ctrlToSIE), 32'hC3);
      tick();
      chk("busy_guard_ctrl", 32'(ctrlToSIE), 32'h00);
      tick(); tick(); tick();
      chk("busy_commit_owner", 32'(activeOwner), 32'd0);
      tick();

      // cancel 0 -> 1 -> 0, with drain condition in the same cycle
      ownerSel = 2'd1;
      sieBusy  = 1'b1;
      tick();
      chk("cancel_switching_rise", 32'(switching), 32'd1);
      tick();
      ownerSel = 2'd0;
      sieBusy  = 1'b0;
      tick();
      chk("cancel_switching_fall", 32'(switching), 32'd0);
      chk("cancel_owner",          32'(activeOwner), 32'd0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("cancel_stays_run", 32'(switching), 32'd0);
      end
      chk("cancel_ctrl", 32'(ctrlToSIE), 32'h11);

      // retarget 0 -> 1 -> 2
      ownerSel = 2'd1;
      sieBusy  = 1'b1;
      push(2'd2, 8'h3C);
      tick();
      chk("retgt_switching", 32'(switching), 32'd1);
      tick();
      ownerSel = 2'd2;
      tick(); tick();
      sieBusy = 1'b0;
      n = 0;
      while (switching && n < 30) begin
         tick();
         n++;
      end
      chk("retgt_settle", 32'(switching), 32'd0);
      chk("retgt_owner",  32'(activeOwner), 32'd2);
      tick();

      // out-of-range request ignored
      ownerSel = 2'd3;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("oor_no_switch", 32'(switching), 32'd0);
      end
      chk("oor_owner", 32'(activeOwner), 32'd2);
      ownerSel = 2'd2;
      tick();

      // stuck sieBusy: timeout or indefinite drain
      ownerSel = 2'd0;
      sieBusy  = 1'b1;
`ifdef SIE_OWNER_MUX_TIMEOUT_EN
      push(2'd0, 8'h22);
      for (int k = 1; k <= 18; k++) begin
         tick();
         chk("timeout_pulse", 32'(timeoutErr), 32'(k == 17));
      end
      chk("timeout_guard", 32'(switching), 32'd1);
      tick(); tick(); tick();
      chk("timeout_commit_owner", 32'(activeOwner), 32'd0);
      tick();
      sieBusy = 1'b0;
`else
      for (int k = 1; k <= 1100; k++) begin
         tick();
         chk("stuck_drain", 32'(switching), 32'd1);
      end
      chk("stuck_no_timeout", 32'(timeoutErr), 32'd0);
      chk("stuck_owner",      32'(activeOwner), 32'd2);
      ownerSel = 2'd2;
      tick(); tick();
      chk("stuck_cancel", 32'(switching), 32'd0);
      sieBusy = 1'b0;
`endif
      tick();

      // reset asserted mid-switch
      ownerSel = 2'd1;
      tick(); tick();
      chk("rst_mid_switching", 32'(switching), 32'd1);
      #2 rstN = 1'b0;
      #1;
      chk("rst_mid_ctrl",      32'(ctrlToSIE), 32'h00);
      chk("rst_mid_owner",     32'(activeOwner), 32'd1);
      chk("rst_mid_switching_clr", 32'(switching), 32'd0);
      chk("rst_mid_done",      32'(switchDone), 32'd0);
      tick(); tick(); tick();
      rstN = 1'b1;
      tick();
      chk("rst_mid_release_ctrl", 32'(ctrlToSIE), 32'hA5);
      chk("rst_mid_release_sw",   32'(switching), 32'd0);
      tick(); tick(); tick();

      chk("sb_empty",   32'(sb.size()), 32'd0);
      chk("sb_pending", 32'(pend), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
